// File: rtl/fuzz_stim_harness_if.sv
// Fuzz-target side of the stimulus harness: the stimulus wires
// into the generated top and its `y` output coming back.
interface fuzz_stim_harness_if;
    logic [2:0] stim_wire0;
    logic [2:0] stim_wire1;
    logic [2:0] stim_wire2;
    logic [1:0] stim_wire3;
    logic       dut_y;

    modport master (
        output stim_wire0, stim_wire1, stim_wire2, stim_wire3,
        input  dut_y
    );

    modport slave (
        input  stim_wire0, stim_wire1, stim_wire2, stim_wire3,
        output dut_y
    );
endinterface

// File: rtl/fuzz_stim_harness.sv
// LFSR stimulus generator and MISR signature compactor for fuzz targets.
// Optional golden comparison enabled by FUZZ_HARNESS_GOLDEN_CMP_EN.
module fuzz_stim_harness #(
    parameter logic [15:0] LFSR_POLY = 16'hB400,
    parameter logic [15:0] MISR_POLY = 16'h1021,
    parameter int          CNT_W     = 16,
    parameter int          LAT       = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [15:0]      seed,
    input  logic [CNT_W-1:0] n_vec,
    fuzz_stim_harness_if.master tgt,
    output logic             busy,
    output logic             done,
    output logic [15:0]      signature
`ifdef FUZZ_HARNESS_GOLDEN_CMP_EN
    ,
    input  logic [15:0]      golden_sig,
    output logic             mismatch
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t           state;
    logic [15:0]      lfsr;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       dcnt;
    logic [LAT-1:0]   pipe;
    logic [10:0]      stim;

    logic [15:0] seed_eff;
    logic [15:0] lfsr_nx;
    logic [15:0] misr_nx;

    // A zero seed would lock the LFSR at zero forever.
    assign seed_eff = (seed == 16'h0000) ? 16'h0001 : seed;
    assign lfsr_nx  = (lfsr >> 1) ^ (lfsr[0] ? LFSR_POLY : 16'h0000);
    assign misr_nx  = (signature << 1)
                    ^ (signature[15] ? MISR_POLY : 16'h0000)
                    ^ {15'b0, tgt.dut_y};

    assign tgt.stim_wire0 = stim[2:0];
    assign tgt.stim_wire1 = stim[5:3];
    assign tgt.stim_wire2 = stim[8:6];
    assign tgt.stim_wire3 = stim[10:9];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            lfsr      <= 16'h0000;
            cnt       <= '0;
            dcnt      <= 2'd0;
            pipe      <= '0;
            stim      <= 11'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            signature <= 16'h0000;
`ifdef FUZZ_HARNESS_GOLDEN_CMP_EN
            mismatch  <= 1'b0;
`endif
        end else begin
            pipe[0] <= (state == RUN);
            for (int i = 1; i < LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end

            // The response to a vector arrives LAT cycles after it.
            if (pipe[LAT-1]) begin
                signature <= misr_nx;
            end

            unique case (state)
                IDLE: begin
                    if (start) begin
                        lfsr      <= seed_eff;
                        cnt       <= n_vec;
                        signature <= 16'h0000;
`ifdef FUZZ_HARNESS_GOLDEN_CMP_EN
                        mismatch  <= 1'b0;
`endif
                        if (n_vec != '0) begin
                            state <= RUN;
                            busy  <= 1'b1;
                            stim  <= seed_eff[10:0];
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    lfsr <= lfsr_nx;
                    cnt  <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state <= DRAIN;
                        dcnt  <= 2'(LAT - 1);
                        stim  <= 11'd0;
                    end else begin
                        stim  <= lfsr_nx[10:0];
                    end
                end
                DRAIN: begin
                    if (dcnt == 2'd0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        dcnt  <= dcnt - 2'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
`ifdef FUZZ_HARNESS_GOLDEN_CMP_EN
                    mismatch <= (signature != golden_sig);
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/fuzz_stim_harness.md
Name: fuzz_stim_harness

Overview:
- Driving end of the fuzz-target interface: generates pseudo-random stimulus for a generated top (1-bit clk, 3/3/3/2-bit data inputs wire0..wire3) and consumes its 1-bit `y` output.
- Compacts `y` into a MISR signature over a programmable number of vectors.
- Sits beside each generated top in the equivalence harness. Signatures from the RTL run and the post-synthesis netlist run are compared to expose synthesis bugs.

Parameters:
- LFSR_POLY, 16'hB400, Galois right-shift feedback mask for the 16-bit stimulus LFSR (maximal length).
- MISR_POLY, 16'h1021, Galois left-shift feedback mask for the 16-bit signature MISR.
- CNT_W, 16, width of the vector counter.
- LAT, 1, pipeline latency in cycles from stimulus applied to `y` valid (1..4).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  run request; sampled only in IDLE.
- seed  input  16  LFSR seed; captured on accepted start.
- n_vec  input  CNT_W  number of vectors to apply; captured on accepted start.
- stim_wire0  output  3  drives DUT wire0.
- stim_wire1  output  3  drives DUT wire1.
- stim_wire2  output  3  drives DUT wire2.
- stim_wire3  output  2  drives DUT wire3.
- dut_y  input  1  DUT output `y`.
- busy  output  1  high in RUN or DRAIN.
- done  output  1  one-cycle pulse; signature is final.
- signature  output  16  MISR value.

Behaviour:
- Reset (async, rst_n=0) forces:
  - state IDLE;
  - all stim outputs 0;
  - busy=0, done=0, signature=0, lfsr=0, valid pipe=0.
- Reset asserted mid-run aborts immediately. No done pulse follows.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 is accepted.
  - On accept: lfsr<=seed (seed 0 is replaced by 16'h0001 to avoid lockup), cnt<=n_vec, signature<=0.
  - Next state is RUN if n_vec!=0, otherwise DONE.
- RUN:
  - Stimulus for the current cycle comes from lfsr: stim_wire0=lfsr[2:0], stim_wire1=lfsr[5:3], stim_wire2=lfsr[8:6], stim_wire3=lfsr[10:9].
  - Each cycle: lfsr<=(lfsr>>1)^(lfsr[0]?LFSR_POLY:0); cnt decrements.
  - The first vector applied is the seed itself.
  - When cnt reaches 1 on a RUN edge, go to DRAIN.
  - Exactly n_vec vectors are applied.
- Stim outputs are 0 in every state except RUN. They are registered outputs, so they change only on clk edges.
- Valid pipeline: an LAT-deep shift register, input = (state==RUN).
- MISR update:
  - Applied on each edge where the pipe output is 1: signature<=(signature<<1)^(signature[15]?MISR_POLY:0)^{15'b0,dut_y}.
  - Exactly n_vec samples are absorbed.
- DRAIN: lasts LAT cycles, then DONE.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- Signature is held until the next accepted start.
- Timing: start accepted at edge E0 with n_vec=N gives done high in the cycle after edge E0+1+N+LAT−1 = E0+N+LAT.
- start while busy or in DONE is ignored (not queued).
- Counter never wraps: n_vec = all-ones is a legal maximum-length run.

Optional Feature:
- Macro: FUZZ_HARNESS_GOLDEN_CMP_EN.
- When defined:
  - Adds input golden_sig[15:0] and output mismatch (1 bit).
  - mismatch is registered and updated on the DONE cycle: mismatch = (MISR value final) != golden_sig.
  - mismatch is sticky until the next accepted start or reset; reset value 0.
- When undefined: neither port exists, and behaviour is otherwise identical.

Test Plan:
- Reset mid-RUN (n_vec=100, abort after 10 vectors) → all outputs 0 immediately while rst_n=0, no done pulse, IDLE after release; a subsequent start works normally.
- seed=16'h0001, n_vec=2, dut_y tied 0:
  - 1st vector: stim_wire0=3'd1, stim_wire1=0, stim_wire2=0, stim_wire3=0;
  - 2nd vector (lfsr=16'hB400): stim_wire3=2'b10, others 0;
  - then all stim 0, done pulse at E0+3, signature=16'h0000.
- seed=16'h0001, dut_y tied 1 → signature 16'h0001 for n_vec=1, 16'h0003 for n_vec=2, 16'h0007 for n_vec=3; busy high for N+LAT cycles.
- n_vec=0 → no RUN cycles, stim stays 0, done pulses in the cycle after accept, signature=0.
- seed=0 → behaves exactly as seed=16'h0001; start pulsed while busy → ignored, run length unchanged.
- With FUZZ_HARNESS_GOLDEN_CMP_EN, seed=1, n_vec=2, dut_y=1:
  - golden_sig=16'h0003 → mismatch=0;
  - golden_sig=16'h0004 → mismatch=1, held until the next start.
